// File: rtl/seq_bit_sampler.sv
// Synchronises and debounces a raw data switch and an "enter bit" pushbutton,
// emitting a one-cycle bit strobe per debounced press plus a bit history and count.
module seq_bit_sampler #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_in,
    input  logic       strobe_in,
    output logic       bit_valid,
    output logic       bit_out,
    output logic [3:0] history,
    output logic [3:0] bit_count
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] data_sync;
    logic [SYNC_STAGES-1:0] strobe_sync;
    logic                   data_sync_out;
    logic                   strobe_sync_out;

    logic             data_stable;
    logic             strobe_stable;
    logic [CNT_W-1:0] data_cnt;
    logic [CNT_W-1:0] strobe_cnt;

    logic strobe_prev;
    logic data_prev;
    logic rise_c;

    assign data_sync_out   = data_sync[SYNC_STAGES-1];
    assign strobe_sync_out = strobe_sync[SYNC_STAGES-1];

    // Metastability chains for both asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync   <= '0;
            strobe_sync <= '0;
        end else begin
            data_sync   <= {data_sync[SYNC_STAGES-2:0], data_in};
            strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], strobe_in};
        end
    end

    // Data debounce: flip only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_stable <= 1'b0;
            data_cnt    <= '0;
        end else if (data_sync_out == data_stable) begin
            data_cnt <= '0;
        end else if (data_cnt == CNT_LAST) begin
            data_stable <= data_sync_out;
            data_cnt    <= '0;
        end else begin
            data_cnt <= data_cnt + CNT_W'(1);
        end
    end

    // Strobe debounce, identical rule
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_stable <= 1'b0;
            strobe_cnt    <= '0;
        end else if (strobe_sync_out == strobe_stable) begin
            strobe_cnt <= '0;
        end else if (strobe_cnt == CNT_LAST) begin
            strobe_stable <= strobe_sync_out;
            strobe_cnt    <= '0;
        end else begin
            strobe_cnt <= strobe_cnt + CNT_W'(1);
        end
    end

    // data_prev lags with strobe_prev so a simultaneous data flip captures the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_prev <= 1'b0;
            data_prev   <= 1'b0;
        end else begin
            strobe_prev <= strobe_stable;
            data_prev   <= data_stable;
        end
    end

    assign rise_c = strobe_stable & ~strobe_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
            history   <= 4'b0000;
            bit_count <= 4'd0;
        end else if (rise_c) begin
            bit_valid <= 1'b1;
            bit_out   <= data_prev;
            history   <= {history[2:0], data_prev};
            bit_count <= bit_count + 4'd1;
        end else begin
            bit_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_bit_sampler.sv
// Directed bench for seq_bit_sampler at SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_seq_bit_sampler;

    logic       clk;
    logic       rst_n;
    logic       data_in;
    logic       strobe_in;
    logic       bit_valid;
    logic       bit_out;
    logic [3:0] history;
    logic [3:0] bit_count;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    seq_bit_sampler #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .strobe_in(strobe_in),
        .bit_valid(bit_valid),
        .bit_out  (bit_out),
        .history  (history),
        .bit_count(bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts high cycles of bit_valid, so one pulse of width 1 adds exactly 1
    always @(negedge clk) if (bit_valid === 1'b1) pulse_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        data_in   = 1'b0;
        strobe_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Clean press: settle data, hold strobe long enough, release and settle
    task automatic press(input logic d, output logic b, output int pulses);
        int start;
        data_in = d;
        repeat (10) tick();
        start     = pulse_cnt;
        strobe_in = 1'b1;
        repeat (12) tick();
        b         = bit_out;
        strobe_in = 1'b0;
        repeat (12) tick();
        pulses = pulse_cnt - start;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        data_in   = 1'b1;
        strobe_in = 1'b1;
        #3;
        checks++;
        if ({bit_valid, bit_out, history, bit_count} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {bit_valid, bit_out, history, bit_count});
        end
        do_reset();
    endtask

    task automatic test_latency();
        int start;
        int rel;
        do_reset();
        data_in = 1'b1;
        repeat (12) tick();
        start     = pulse_cnt;
        strobe_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (bit_valid !== (i == 7)) begin
                errors++;
                $display("FAIL latency_edge%0d bit_valid got %b exp %b", i, bit_valid, (i == 7));
            end
        end
        checks++;
        if ({bit_out, history, bit_count} !== {1'b1, 4'b0001, 4'd1}) begin
            errors++;
            $display("FAIL latency_outputs got bit_out=%b hist=%b cnt=%0d exp 1 0001 1",
                     bit_out, history, bit_count);
        end
        checks++;
        if (pulse_cnt - start !== 1) begin
            errors++;
            $display("FAIL latency_pulses got %0d exp 1", pulse_cnt - start);
        end
        rel       = pulse_cnt;
        strobe_in = 1'b0;
        repeat (20) tick();
        checks++;
        if (pulse_cnt - rel !== 0) begin
            errors++;
            $display("FAIL release_pulse got %0d exp 0", pulse_cnt - rel);
        end
    endtask

    task automatic test_glitch();
        int start;
        do_reset();
        start     = pulse_cnt;
        strobe_in = 1'b1; repeat (3) tick();
        strobe_in = 1'b0; repeat (2) tick();
        strobe_in = 1'b1; repeat (3) tick();
        strobe_in = 1'b0; repeat (20) tick();
        checks++;
        if (pulse_cnt - start !== 0) begin
            errors++;
            $display("FAIL glitch_pulses got %0d exp 0", pulse_cnt - start);
        end
        checks++;
        if (bit_count !== 4'd0) begin
            errors++;
            $display("FAIL glitch_count got %0d exp 0", bit_count);
        end
    endtask

    task automatic test_sequence();
        logic [4:0] bits;
        logic       b;
        int         p;
        bits = 5'b01101;
        do_reset();
        for (int i = 4; i >= 0; i--) begin
            press(bits[i], b, p);
            checks++;
            if (b !== bits[i] || p !== 1) begin
                errors++;
                $display("FAIL seq_bit%0d got bit=%b pulses=%0d exp bit=%b pulses=1",
                         4 - i, b, p, bits[i]);
            end
        end
        checks++;
        if (history !== 4'b1101 || bit_count !== 4'd5) begin
            errors++;
            $display("FAIL seq_final got hist=%b cnt=%0d exp 1101 5", history, bit_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_cnt [3];
        logic       b;
        int         p;
        exp_cnt[0] = 4'd15;
        exp_cnt[1] = 4'd0;
        exp_cnt[2] = 4'd1;
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            press(1'b1, b, p);
            if (k >= 15) begin
                checks++;
                if (bit_count !== exp_cnt[k-15] || p !== 1) begin
                    errors++;
                    $display("FAIL wrap_press%0d got cnt=%0d pulses=%0d exp cnt=%0d pulses=1",
                             k, bit_count, p, exp_cnt[k-15]);
                end
            end
        end
        checks++;
        if (history !== 4'b1111) begin
            errors++;
            $display("FAIL wrap_history got %b exp 1111", history);
        end
    endtask

    task automatic test_reset_mid_press();
        int start;
        do_reset();
        data_in = 1'b1;
        repeat (10) tick();
        start     = pulse_cnt;
        strobe_in = 1'b1;
        repeat (3) tick();
        rst_n     = 1'b0;
        strobe_in = 1'b0;
        repeat (3) tick();
        rst_n   = 1'b1;
        data_in = 1'b0;
        repeat (20) tick();
        checks++;
        if (pulse_cnt - start !== 0) begin
            errors++;
            $display("FAIL midreset_pulses got %0d exp 0", pulse_cnt - start);
        end
        checks++;
        if ({bit_valid, bit_out, history, bit_count} !== 10'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %b exp 0", {bit_valid, bit_out, history, bit_count});
        end
    endtask

    task automatic test_simultaneous();
        int   start;
        logic b;
        int   p;
        do_reset();
        repeat (10) tick();
        start     = pulse_cnt;
        data_in   = 1'b1;
        strobe_in = 1'b1;
        repeat (12) tick();
        checks++;
        if (pulse_cnt - start !== 1 || bit_out !== 1'b0 || history !== 4'b0000 || bit_count !== 4'd1) begin
            errors++;
            $display("FAIL simul_capture got pulses=%0d bit=%b hist=%b cnt=%0d exp 1 0 0000 1",
                     pulse_cnt - start, bit_out, history, bit_count);
        end
        strobe_in = 1'b0;
        repeat (12) tick();
        press(1'b1, b, p);
        checks++;
        if (b !== 1'b1 || p !== 1 || history !== 4'b0001 || bit_count !== 4'd2) begin
            errors++;
            $display("FAIL simul_next got bit=%b pulses=%0d hist=%b cnt=%0d exp 1 1 0001 2",
                     b, p, history, bit_count);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        data_in   = 1'b0;
        strobe_in = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_sequence();
        test_back_to_back();
        test_reset_mid_press();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
